// File: rtl/rom_programmer_pkg.sv
// Shared constants and types for the 556PT4/556PT5 fuse-programming engine.
package rom_programmer_pkg;

    // V1..V4 operation bus codes (bit0 = V1 ... bit3 = V4)
    localparam logic [3:0] OP_OFF     = 4'b0000;
    localparam logic [3:0] OP_READ    = 4'b1100;
    localparam logic [3:0] OP_PROGRAM = 4'b0011;

    // Chip geometries, also used by the read path
    localparam int PT5_DATA_WIDTH    = 8;   // 556PT5 / 3604
    localparam int PT5_ADDRESS_WIDTH = 9;
    localparam int PT4_DATA_WIDTH    = 4;   // 556PT4 / 3601
    localparam int PT4_ADDRESS_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SAMPLE,
        PULSE,
        RECOVER,
        DONE,
        ERROR
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a bit index into a word; never narrower than one bit
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_programmer_if.sv
// Host handshake plus programming-socket signals of the fuse programmer.
interface rom_programmer_if #(
    parameter int DATA_WIDTH    = rom_programmer_pkg::PT5_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = rom_programmer_pkg::PT5_ADDRESS_WIDTH
);
    import rom_programmer_pkg::*;

    localparam int BIT_INDEX_WIDTH = index_width(DATA_WIDTH);

    // host side
    logic                       start;
    logic [ADDRESS_WIDTH-1:0]   address_in;
    logic [DATA_WIDTH-1:0]      data_in;
    logic                       ready;
    logic                       done;
    logic                       error;
    logic [BIT_INDEX_WIDTH-1:0] error_bit;

    // socket side
    logic [DATA_WIDTH-1:0]      data_line_in;
    logic [3:0]                 operation;
    logic [ADDRESS_WIDTH-1:0]   address_line;
    logic [DATA_WIDTH-1:0]      data_line_out;
    logic [DATA_WIDTH-1:0]      data_line_oe;

    // Host controller and socket model drive the engine through this view
    modport master (
        output start, address_in, data_in, data_line_in,
        input  ready, done, error, error_bit,
        input  operation, address_line, data_line_out, data_line_oe
    );

    // The programming engine itself
    modport slave (
        input  start, address_in, data_in, data_line_in,
        output ready, done, error, error_bit,
        output operation, address_line, data_line_out, data_line_oe
    );

endinterface

// File: rtl/rom_programmer_bit_select.sv
// Picks the next fuse to blow: lowest bit wanted by the target but not yet read back.
module prog_bit_select #(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 3
) (
    input  logic [DATA_WIDTH-1:0]  target_i,
    input  logic [DATA_WIDTH-1:0]  rb_i,
    output logic [INDEX_WIDTH-1:0] idx_o,
    output logic                   pending_o,
    output logic                   conflict_o
);

    logic [DATA_WIDTH-1:0] pending_bits;

    assign pending_bits = target_i & ~rb_i;
    assign pending_o    = |pending_bits;
    // a blown fuse cannot be restored, so any extra 1 is unrecoverable
    assign conflict_o   = |(rb_i & ~target_i);

    // Priority encoder: scanning downwards leaves the lowest set bit last
    always_comb begin
        idx_o = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (pending_bits[i]) begin
                idx_o = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/rom_programmer.sv
// Bit-serial fuse programmer: settle, sample, pulse the lowest missing bit, repeat.
module rom_programmer
    import rom_programmer_pkg::*;
#(
    parameter int DATA_WIDTH    = PT5_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = PT5_ADDRESS_WIDTH,
    parameter int SETTLE_CYCLES = 16,
    parameter int PULSE_CYCLES  = 64,
    parameter int MAX_RETRIES   = 8
) (
    input  logic            clk,
    input  logic            reset,
    rom_programmer_if.slave bus
);

    localparam int BIT_INDEX_WIDTH = index_width(DATA_WIDTH);
    localparam int TIMER_WIDTH     = $clog2(max_int(SETTLE_CYCLES, PULSE_CYCLES) + 1);
    localparam int RETRY_WIDTH     = $clog2(MAX_RETRIES + 1);

    localparam logic [TIMER_WIDTH-1:0] SETTLE_LAST = TIMER_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] PULSE_LAST  = TIMER_WIDTH'(PULSE_CYCLES - 1);
    localparam logic [RETRY_WIDTH-1:0] RETRY_LIMIT = RETRY_WIDTH'(MAX_RETRIES);

    state_t                     state_q,   state_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]      target_q,  target_d;
    logic [BIT_INDEX_WIDTH-1:0] bit_q,     bit_d;
    logic [BIT_INDEX_WIDTH-1:0] err_bit_q, err_bit_d;
    logic [RETRY_WIDTH-1:0]     retry_q,   retry_d;
    logic [TIMER_WIDTH-1:0]     timer_q,   timer_d;

    logic [BIT_INDEX_WIDTH-1:0] sel_idx;
    logic                       sel_pending;
    logic                       sel_conflict;
    logic [RETRY_WIDTH-1:0]     retry_eff;

    logic                       ready_s;
    logic                       done_s;
    logic                       error_s;
    logic [3:0]                 operation_s;
    logic [DATA_WIDTH-1:0]      drive_s;

    // The readback is judged on the SAMPLE cycle itself, so the decision and the
    // capture of the chosen bit happen on the same edge.
    prog_bit_select #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (BIT_INDEX_WIDTH)
    ) u_bit_select (
        .target_i   (target_q),
        .rb_i       (bus.data_line_in),
        .idx_o      (sel_idx),
        .pending_o  (sel_pending),
        .conflict_o (sel_conflict)
    );

    // Moving on to a different bit starts its pulse budget afresh
    assign retry_eff = (sel_idx != bit_q) ? '0 : retry_q;

    // State and datapath registers; reset drops the drivers without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            target_q  <= '0;
            bit_q     <= '0;
            err_bit_q <= '0;
            retry_q   <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            target_q  <= target_d;
            bit_q     <= bit_d;
            err_bit_q <= err_bit_d;
            retry_q   <= retry_d;
            timer_q   <= timer_d;
        end
    end

    // Next state, phase timer, retry bookkeeping and job latching
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        target_d  = target_q;
        bit_d     = bit_q;
        err_bit_d = err_bit_q;
        retry_d   = retry_q;
        timer_d   = timer_q + TIMER_WIDTH'(1);
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (bus.start) begin
                    state_d  = SETUP;
                    addr_d   = bus.address_in;
                    target_d = bus.data_in;
                    retry_d  = '0;
                    bit_d    = '0;
                end
            end
            SETUP: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    timer_d = '0;
                end
            end
            SAMPLE: begin
                timer_d = '0;
                if (sel_conflict) begin
                    state_d   = ERROR;
                    err_bit_d = '0;
                end else if (!sel_pending) begin
                    state_d = DONE;
                end else if (retry_eff == RETRY_LIMIT) begin
                    state_d   = ERROR;
                    err_bit_d = sel_idx;
                end else begin
                    state_d = PULSE;
                    bit_d   = sel_idx;
                    retry_d = retry_eff + RETRY_WIDTH'(1);
                end
            end
            PULSE: begin
                if (timer_q == PULSE_LAST) begin
                    state_d = RECOVER;
                    timer_d = '0;
                end
            end
            RECOVER: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    timer_d = '0;
                end
            end
            default: begin
                // DONE and ERROR last one cycle
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs decoded from state only, so drive and OP_PROGRAM switch on the same edge
    always_comb begin
        ready_s     = 1'b0;
        done_s      = 1'b0;
        error_s     = 1'b0;
        operation_s = OP_OFF;
        drive_s     = '0;
        case (state_q)
            IDLE:                   ready_s = 1'b1;
            SETUP, SAMPLE, RECOVER: operation_s = OP_READ;
            PULSE: begin
                operation_s = OP_PROGRAM;
                drive_s     = DATA_WIDTH'(1) << bit_q;
            end
            DONE:                   done_s = 1'b1;
            ERROR:                  error_s = 1'b1;
            default:                ready_s = 1'b0;
        endcase
    end

    assign bus.ready         = ready_s;
    assign bus.done          = done_s;
    assign bus.error         = error_s;
    assign bus.error_bit     = err_bit_q;
    assign bus.operation     = operation_s;
    assign bus.address_line  = addr_q;
    assign bus.data_line_out = drive_s;
    assign bus.data_line_oe  = drive_s;

endmodule

// File: tb/tb_rom_programmer.sv
// Self-checking bench: PROM socket model plus a timeline model of the programming job.
module tb_rom_programmer;
    import rom_programmer_pkg::*;

    localparam int DW = 8;
    localparam int AW = 9;
    localparam int S  = 3;
    localparam int P  = 5;
    localparam int MR = 4;
    localparam int L  = P + S + 1;     // cycles added by one pulse

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rom_programmer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    rom_programmer #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .SETTLE_CYCLES (S),
        .PULSE_CYCLES  (P),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Fuse array of the socketed chip; outputs valid only in read mode
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign bus.data_line_in = (bus.operation == OP_READ) ? mem[bus.address_line] : '0;

    int tests = 0;
    int fails = 0;

    // job model
    bit            m_active = 0;
    int            m_k = 0;
    int            m_np = 0;
    int            m_bits [64];
    bit            m_err = 0;
    int            m_eb = 0;
    logic [AW-1:0] m_addr = '0;
    int            model_accepts = 0;

    // chip behaviour: pulses needed per bit (0 = fuse never blows)
    int need_cfg [DW];
    int need_job [DW];
    int cnt      [DW];

    // observations of the DUT
    bit prev_prog = 0;
    bit prev_ready = 1;
    bit saw_prog = 0;
    bit obs_done = 0;
    bit obs_err = 0;
    int obs_eb = 0;
    int obs_end_k = 0;
    int dut_accepts = 0;
    int pulse_log [$];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of one clock cycle, evaluated mid-cycle
    task automatic model_cycle();
        logic          e_ready, e_done, e_err;
        logic [3:0]    e_op;
        logic [DW-1:0] e_oe;
        logic [DW-1:0] t, r0;
        bit            idle_now, prog;
        int            m, j, r, b;
        e_ready = 1'b0; e_done = 1'b0; e_err = 1'b0; e_op = OP_OFF; e_oe = '0;
        idle_now = 0;
        if (reset) begin
            m_active = 0;
            m_addr   = '0;
            e_ready  = 1'b1;
        end else if (!m_active) begin
            e_ready  = 1'b1;
            idle_now = 1;
        end else begin
            m_k++;
            if (m_k <= S + 1) begin
                e_op = OP_READ;                 // settle, then sample
            end else begin
                m = m_k - (S + 2);
                j = m / L;
                r = m % L;
                if (j < m_np) begin
                    if (r < P) begin
                        e_op = OP_PROGRAM;
                        e_oe = DW'(1) << m_bits[j];
                    end else begin
                        e_op = OP_READ;         // recover + sample
                    end
                end else begin
                    e_done   = !m_err;
                    e_err    = m_err;
                    m_active = 0;
                end
            end
        end

        check($sformatf("cycle k=%0d {rdy,done,err,op,oe,out,addr}", m_k),
              {bus.ready, bus.done, bus.error, bus.operation, bus.data_line_oe,
               bus.data_line_out, bus.address_line},
              {e_ready, e_done, e_err, e_op, e_oe, e_oe, m_addr});
        if (e_err) check("error_bit", longint'(bus.error_bit), m_eb);

        if (reset) begin
            prev_prog  = 0;
            prev_ready = 1;
        end else begin
            if (bus.done || bus.error) begin
                obs_done  = bus.done;
                obs_err   = bus.error;
                obs_eb    = int'(bus.error_bit);
                obs_end_k = m_k;
            end
            if (prev_ready && !bus.ready) dut_accepts++;
            prev_ready = bus.ready;
            prog = (bus.operation == OP_PROGRAM);
            if (prog) saw_prog = 1;
            if (prog && !prev_prog) begin
                b = -1;
                for (int i = DW - 1; i >= 0; i--) if (bus.data_line_oe[i]) b = i;
                pulse_log.push_back(b);
                if (b >= 0) begin
                    cnt[b]++;
                    if (need_job[b] != 0 && cnt[b] >= need_job[b])
                        mem[bus.address_line][b] = 1'b1;
                end
            end
            prev_prog = prog;
        end

        // accept on the edge closing this idle cycle
        if (idle_now && bus.start) begin
            m_active = 1;
            m_k      = 0;
            model_accepts++;
            m_addr   = bus.address_in;
            t        = bus.data_in;
            r0       = mem[bus.address_in];
            for (int i = 0; i < DW; i++) begin
                need_job[i] = need_cfg[i];
                cnt[i]      = 0;
            end
            pulse_log.delete();
            saw_prog = 0;
            obs_done = 0;
            obs_err  = 0;
            m_np  = 0;
            m_err = 0;
            m_eb  = 0;
            if ((r0 & ~t) != '0) begin
                m_err = 1;
            end else begin
                for (int i = 0; i < DW; i++) begin
                    if (t[i] && !r0[i] && !m_err) begin
                        for (int c = 0; c < ((need_job[i] == 0) ? MR : need_job[i]); c++) begin
                            m_bits[m_np] = i;
                            m_np++;
                        end
                        if (need_job[i] == 0) begin
                            m_err = 1;
                            m_eb  = i;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 5000 && m_active; i++) step();
        check("job_finished_in_budget", m_active, 0);
    endtask

    task automatic run_job(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] init);
        mem[a]         = init;
        bus.address_in = a;
        bus.data_in    = d;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        wait_end();
        $display("[TB] job addr=%03h target=%02h init=%02h pulses=%0d done=%0d error=%0d bit=%0d",
                 a, d, init, pulse_log.size(), obs_done, obs_err, obs_eb);
    endtask

    task automatic set_need_all(input int n);
        for (int i = 0; i < DW; i++) need_cfg[i] = n;
    endtask

    initial begin
        int exp_a5 [4];
        int acc0, ma0;
        logic [DW-1:0] tgt, init;
        exp_a5 = '{0, 2, 5, 7};
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        set_need_all(1);
        bus.start      = 1'b0;
        bus.address_in = '0;
        bus.data_in    = '0;

        // reset state
        step(); step();
        check("reset_ready", bus.ready, 1);
        check("reset_done_error", {bus.done, bus.error}, 0);
        check("reset_error_bit", bus.error_bit, 0);
        check("reset_operation", bus.operation, 0);
        check("reset_address_line", bus.address_line, 0);
        check("reset_drive", {bus.data_line_oe, bus.data_line_out}, 0);
        reset = 1'b0;
        step();

        // blank cell to 0xA5, each fuse blows on its first pulse
        run_job(9'h012, 8'hA5, 8'h00);
        check("a5_pulse_count", pulse_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("a5_pulse%0d_bit", i), (i < pulse_log.size()) ? pulse_log[i] : -1, exp_a5[i]);
        check("a5_done", obs_done, 1);
        check("a5_error", obs_err, 0);

        // already programmed word: no pulse, done at accept + S + 2
        run_job(9'h155, 8'h3C, 8'h3C);
        check("3c_no_program", saw_prog, 0);
        check("3c_done_latency", obs_end_k, 5);
        check("3c_done", obs_done, 1);

        // readback 0xFF against target 0x0F: conflict
        run_job(9'h0A0, 8'h0F, 8'hFF);
        check("conflict_error", obs_err, 1);
        check("conflict_error_bit", obs_eb, 0);
        check("conflict_pulses", pulse_log.size(), 0);

        // bit 3 never blows: MAX_RETRIES pulses then error on bit 3
        need_cfg[3] = 0;
        run_job(9'h1FF, 8'h08, 8'h00);
        check("stuck_pulses", pulse_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("stuck_pulse%0d_bit", i), (i < pulse_log.size()) ? pulse_log[i] : -1, 3);
        check("stuck_error", obs_err, 1);
        check("stuck_error_bit", obs_eb, 3);
        set_need_all(1);

        // reset in the middle of a pulse
        need_cfg[1] = 0;
        mem[9'h040]    = '0;
        bus.address_in = 9'h040;
        bus.data_in    = 8'h02;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 200 && bus.operation != OP_PROGRAM; i++) step();
        step();
        #2;
        check("pulse_on_before_reset", {bus.operation, bus.data_line_oe}, {OP_PROGRAM, 8'h02});
        reset = 1'b1;
        #1;
        check("reset_kills_oe", bus.data_line_oe, 0);
        check("reset_kills_operation", bus.operation, 0);
        $display("[TB] reset mid-pulse: op=%04b oe=%02h", bus.operation, bus.data_line_oe);
        step(); step();
        reset = 1'b0;
        #1;
        check("ready_after_reset", bus.ready, 1);
        step();
        set_need_all(1);

        // start held through a whole job: exactly one accept, next job right after
        acc0 = dut_accepts;
        ma0  = model_accepts;
        mem[9'h101]    = 8'h00;
        mem[9'h0F0]    = 8'h10;
        bus.address_in = 9'h101;
        bus.data_in    = 8'h81;
        bus.start      = 1'b1;
        step();
        bus.address_in = 9'h0F0;
        bus.data_in    = 8'h30;
        for (int i = 0; i < 2000 && model_accepts < ma0 + 2; i++) step();
        bus.start = 1'b0;
        wait_end();
        check("held_accepts", dut_accepts - acc0, 2);
        check("held_job2_address", bus.address_line, 9'h0F0);
        check("held_job2_done", obs_done, 1);
        $display("[TB] held start: accepts=%0d last addr=%03h", dut_accepts - acc0, bus.address_line);

        // randomized jobs against the model
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < DW; i++)
                need_cfg[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MR));
            tgt  = DW'($urandom);
            init = ($urandom_range(0, 3) == 0) ? DW'($urandom) : (tgt & DW'($urandom));
            run_job(AW'($urandom_range(0, (1 << AW) - 1)), tgt, init);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rom_programmer.md
# rom_programmer

Fuse-programming engine for 556PT5 (3604) and 556PT4 (3601) bipolar PROMs. It is the write-side counterpart of the existing read path. It accepts one address/data word per handshake and drives the chip's address lines and the V1–V4 operation bus. It blows fuses one bit at a time with timed pulses, re-reading the cell after each pulse, and reports done or error. It sits between the host/control logic and the programming socket drivers, sharing the address and operation pins with the reader through top-level muxing.

## Interface
Parameters:
- DATA_WIDTH, 8: word width; 8 for 3604, 4 for 3601.
- ADDRESS_WIDTH, 9: address width; 9 for 3604, 8 for 3601.
- SETTLE_CYCLES, 16: cycles of read-mode settling before each sample; must be ≥ 1.
- PULSE_CYCLES, 64: cycles one programming pulse is held; must be ≥ 1.
- MAX_RETRIES, 8: maximum pulses allowed on a single bit before error; must be ≥ 1.

Ports (clock and reset first):
- clk, input, 1: single clock; all logic is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: request to program one word; sampled only when ready=1.
- address_in, input, ADDRESS_WIDTH: target address; latched on accept.
- data_in, input, DATA_WIDTH: target word; latched on accept.
- data_line_in, input, DATA_WIDTH: chip outputs, used for readback.
- ready, output, 1: engine is in IDLE and will accept start.
- done, output, 1: one-cycle pulse; the word was verified equal to the target.
- error, output, 1: one-cycle pulse; the word failed.
- error_bit, output, $clog2(DATA_WIDTH) (minimum 1): failing bit index; 0 for a conflict error; valid while error=1.
- operation, output, 4: V1..V4 control; bit0=V1 … bit3=V4.
- address_line, output, ADDRESS_WIDTH: chip address.
- data_line_out, output, DATA_WIDTH: programming drive pattern, one-hot during a pulse.
- data_line_oe, output, DATA_WIDTH: per-bit output enable of the programming drivers.

## Operation
- Bit polarity: a blank cell reads 0; programming a cell sets it to 1; a 1 can never be returned to 0.
- Operation codes: OP_OFF=4'b0000, OP_READ=4'b1100, OP_PROGRAM=4'b0011.
- IDLE
  - Outputs: ready=1, operation=OP_OFF, data_line_oe=0.
  - start=1 latches address_in/data_in, clears the retry counter, and moves to SETUP.
- SETUP
  - Outputs: operation=OP_READ, address_line=latched address.
  - Counts SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE (1 cycle): registers data_line_in into rb, then decides:
  - (rb & ~target) ≠ 0 → ERROR (conflict), error_bit=0.
  - rb == target → DONE.
  - Otherwise select bit b = lowest set bit of (target & ~rb).
    - If b differs from the previously pulsed bit, clear the retry counter.
    - If the retry counter == MAX_RETRIES → ERROR, error_bit=b.
    - Otherwise go to PULSE.
- PULSE
  - Outputs: operation=OP_PROGRAM, data_line_out = data_line_oe = 1<<b.
  - Held for PULSE_CYCLES cycles; the retry counter increments on entry.
- RECOVER
  - Outputs: data_line_oe=0, operation=OP_READ.
  - Counts SETTLE_CYCLES cycles, then returns to SAMPLE.
- DONE / ERROR (1 cycle each)
  - Assert done or error, drive operation=OP_OFF, then return to IDLE.
- start outside IDLE is ignored; there is no queueing.
- address_line holds the latched value from accept until the next accept, including through IDLE.

## Timing
- Reset values (applied asynchronously):
  - state=IDLE, ready=1, done=0, error=0, error_bit=0.
  - operation=OP_OFF, address_line=0, data_line_out=0, data_line_oe=0.
- Reset during PULSE removes drive immediately, not at the next edge; it is the safety path.
- Accept occurs on edge T. ready falls at T+1 and SETUP runs for cycles T+1 … T+SETTLE_CYCLES.
- SAMPLE occurs at cycle T+SETTLE_CYCLES+1.
- Word needing no pulses: done is high during cycle T+SETTLE_CYCLES+2; ready returns the following cycle.
- Each pulse adds PULSE_CYCLES + SETTLE_CYCLES + 1 cycles.
- data_line_oe and OP_PROGRAM change on the same edge, both on entry and on exit, so drive never overlaps OP_READ.
- Counters are width $clog2(max(SETTLE_CYCLES, PULSE_CYCLES)+1), and are compared to N-1.
- The retry counter is width $clog2(MAX_RETRIES+1).

## Structure
- Package rom_programmer_pkg holds:
  - OP_OFF, OP_READ, OP_PROGRAM.
  - The state enum: IDLE, SETUP, SAMPLE, PULSE, RECOVER, DONE, ERROR.
  - The chip-type width constants shared with the reader.
- Sub-module prog_bit_select (combinational): takes target and rb, and returns the lowest pending bit index, a pending flag, and a conflict flag.
- Everything else is a single FSM with two counters (timer, retry).

## Test plan
- Blank chip programmed to 0xA5 (model sets a bit after 1 pulse):
  - Exactly 4 pulses, on bits 0, 2, 5, 7, in that order.
  - done=1 and error=0.
- Readback already 0x3C, target 0x3C:
  - No OP_PROGRAM ever appears.
  - done exactly SETTLE_CYCLES+2 cycles after accept.
- Readback 0xFF, target 0x0F: error with error_bit=0, and zero pulses issued.
- Bit 3 of target 0x08 never sets in the model: exactly MAX_RETRIES pulses, then error with error_bit=3.
- reset asserted mid-PULSE: data_line_oe=0 and operation=0000 before the next clk edge; ready=1 after release.
- start held high through an entire job:
  - Only one accept occurs.
  - A second job begins on the cycle ready returns high, with newly latched address/data.
